wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file write port (A3/WD3/WE3).
- Merges results from two producers, ALU and load unit, into a DEPTH-entry FIFO and drains one entry per cycle into the single write port.
- Exports a pending-write mask so issue logic can detect RAW hazards on registers with queued writes.

---
 rtl/wb_arbiter_if.sv | 32 +++
 rtl/wb_arbiter.sv | 110 +++++++++++
 tb/tb_wb_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU/load producer handshakes, stall input, register-file write port, occupancy and hazard mask.
// The arbiter takes the slave modport; the producer/regfile side takes the master modport.
interface wb_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
);
  logic                     alu_valid;
  logic [AW-1:0]            alu_rd;
  logic [DW-1:0]            alu_data;
  logic                     alu_ready;
  logic                     mem_valid;
  logic [AW-1:0]            mem_rd;
  logic [DW-1:0]            mem_data;
  logic                     mem_ready;
  logic                     wb_stall;
  logic                     WE3;
  logic [AW-1:0]            A3;
  logic [DW-1:0]            WD3;
  logic [$clog2(DEPTH):0]   count;
  logic [(1<<AW)-1:0]       pending_mask;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, wb_stall,
    output alu_ready, mem_ready, WE3, A3, WD3, count, pending_mask
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, wb_stall,
    input  alu_ready, mem_ready, WE3, A3, WD3, count, pending_mask
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin merge of ALU and load results into a DEPTH-entry FIFO draining to the regfile port.
// Latency: accept at edge N, WE3 during cycle N+1. Backpressure: ready drops when full; wb_stall holds the head.
// Optional WB_DROP_X0_EN: accepted results targeting register 0 are consumed but never queued.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {SRC_ALU, SRC_MEM} src_e;

  src_e          last_grant_q, last_grant_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_q   [DEPTH];
  logic [AW-1:0] rd_d   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];

  logic          full, empty;
  logic          alu_push, mem_push, accept, enq, pop;
  logic [AW-1:0] push_rd;
  logic [DW-1:0] push_data;
  logic [DEPTH-1:0]    entry_vld;
  logic [(1<<AW)-1:0]  mask;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // At most one ready is high when both producers request; the loser is the last winner.
  assign bus.alu_ready = !full && (!bus.mem_valid || last_grant_q == SRC_MEM);
  assign bus.mem_ready = !full && (!bus.alu_valid || last_grant_q == SRC_ALU);

  assign alu_push  = bus.alu_valid && bus.alu_ready;
  assign mem_push  = bus.mem_valid && bus.mem_ready;
  assign accept    = alu_push || mem_push;
  assign push_rd   = alu_push ? bus.alu_rd   : bus.mem_rd;
  assign push_data = alu_push ? bus.alu_data : bus.mem_data;
`ifdef WB_DROP_X0_EN
  assign enq = accept && (push_rd != '0);
`else
  assign enq = accept;
`endif
  assign pop = !empty && !bus.wb_stall;

  always_comb begin
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_d         = rd_q;
    data_d       = data_q;
    if (accept) begin
      last_grant_d = alu_push ? SRC_ALU : SRC_MEM;
    end
    if (enq) begin
      rd_d[wr_ptr_q]   = push_rd;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(enq) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= SRC_MEM;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    entry_vld = '0;
    mask      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_vld[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
      if (entry_vld[i]) begin
        mask[rd_q[i]] = 1'b1;
      end
    end
  end

  assign bus.WE3          = pop;
  assign bus.A3           = empty ? '0 : rd_q[rd_ptr_q];
  assign bus.WD3          = empty ? '0 : data_q[rd_ptr_q];
  assign bus.count        = count_q;
  assign bus.pending_mask = mask;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
module tb_wb_arbiter;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  wb_arbiter_if #(.DEPTH(4), .DW(32), .AW(5)) bus ();

  wb_arbiter #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.wb_stall  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    n_total++; if (bus.count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else n_pass++;
    n_total++; if (bus.WE3 !== 1'b0) $display("FAIL reset_we3 got=%0b exp=0", bus.WE3); else n_pass++;
    n_total++; if (bus.A3 !== 5'd0) $display("FAIL reset_a3 got=%0d exp=0", bus.A3); else n_pass++;
    n_total++; if (bus.WD3 !== 32'd0) $display("FAIL reset_wd3 got=%0h exp=0", bus.WD3); else n_pass++;
    n_total++; if (bus.pending_mask !== 32'd0) $display("FAIL reset_mask got=%0h exp=0", bus.pending_mask); else n_pass++;
    n_total++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1)
      $display("FAIL reset_ready got=%0b%0b exp=11", bus.alu_ready, bus.mem_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_single();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    n_total++; if (bus.alu_ready !== 1'b1) $display("FAIL single_ready got=%0b exp=1", bus.alu_ready); else n_pass++;
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
    #1;
    n_total++; if (bus.WE3 !== 1'b1) $display("FAIL single_we3 got=%0b exp=1", bus.WE3); else n_pass++;
    n_total++; if (bus.A3 !== 5'd5) $display("FAIL single_a3 got=%0d exp=5", bus.A3); else n_pass++;
    n_total++; if (bus.WD3 !== 32'hDEADBEEF) $display("FAIL single_wd3 got=%0h exp=deadbeef", bus.WD3); else n_pass++;
    n_total++; if (bus.pending_mask !== 32'h0000_0020) $display("FAIL single_mask got=%0h exp=20", bus.pending_mask); else n_pass++;
    n_total++; if (bus.count !== 3'd1) $display("FAIL single_count got=%0d exp=1", bus.count); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (bus.count !== 3'd0) $display("FAIL single_count_after got=%0d exp=0", bus.count); else n_pass++;
    n_total++; if (bus.WE3 !== 1'b0) $display("FAIL single_we3_after got=%0b exp=0", bus.WE3); else n_pass++;
    n_total++; if (bus.pending_mask !== 32'd0) $display("FAIL single_mask_after got=%0h exp=0", bus.pending_mask); else n_pass++;
  endtask

  task automatic test_round_robin();
    int ai;
    int mi;
    int exp_rd;
    ai = 0;
    mi = 0;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(1 + ai);  bus.alu_data = 32'(101 + ai);
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(11 + mi); bus.mem_data = 32'(211 + mi);
      #1;
      n_total++; if (bus.alu_ready !== (k % 2 == 0))
        $display("FAIL rr_alu_ready k=%0d got=%0b exp=%0b", k, bus.alu_ready, (k % 2 == 0)); else n_pass++;
      n_total++; if (bus.mem_ready !== (k % 2 == 1))
        $display("FAIL rr_mem_ready k=%0d got=%0b exp=%0b", k, bus.mem_ready, (k % 2 == 1)); else n_pass++;
      if (k > 0) begin
        exp_rd = ((k - 1) % 2 == 0) ? 1 + (k - 1) / 2 : 11 + (k - 1) / 2;
        n_total++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'(exp_rd))
          $display("FAIL rr_write k=%0d got we=%0b a3=%0d exp we=1 a3=%0d", k, bus.WE3, bus.A3, exp_rd); else n_pass++;
      end
      @(posedge clk); #1;
      if (k % 2 == 0) ai++; else mi++;
    end
    idle_inputs();
    #1;
    n_total++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd12 || bus.WD3 !== 32'd212)
      $display("FAIL rr_last got we=%0b a3=%0d wd=%0d exp we=1 a3=12 wd=212", bus.WE3, bus.A3, bus.WD3); else n_pass++;
    @(posedge clk); #2;
  endtask

  task automatic test_stall_full();
    apply_reset();
    bus.wb_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(k + 1); bus.alu_data = 32'(16 + k);
      #1;
      n_total++; if (bus.alu_ready !== 1'b1) $display("FAIL stall_fill_ready k=%0d got=%0b exp=1", k, bus.alu_ready); else n_pass++;
      @(posedge clk); #1;
    end
    bus.alu_rd = 5'd5; bus.alu_data = 32'd20;
    #1;
    n_total++; if (bus.alu_ready !== 1'b0) $display("FAIL full_ready got=%0b exp=0", bus.alu_ready); else n_pass++;
    n_total++; if (bus.count !== 3'd4) $display("FAIL full_count got=%0d exp=4", bus.count); else n_pass++;
    n_total++; if (bus.WE3 !== 1'b0) $display("FAIL stall_we3 got=%0b exp=0", bus.WE3); else n_pass++;
    bus.wb_stall = 1'b0;
    #1;
    n_total++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd1 || bus.WD3 !== 32'd16)
      $display("FAIL drain0 got we=%0b a3=%0d wd=%0d exp we=1 a3=1 wd=16", bus.WE3, bus.A3, bus.WD3); else n_pass++;
    n_total++; if (bus.alu_ready !== 1'b0) $display("FAIL full_pop_no_pass got=%0b exp=0", bus.alu_ready); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (bus.alu_ready !== 1'b1) $display("FAIL refill_ready got=%0b exp=1", bus.alu_ready); else n_pass++;
    n_total++; if (bus.A3 !== 5'd2) $display("FAIL drain1 got a3=%0d exp=2", bus.A3); else n_pass++;
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
    for (int j = 2; j < 5; j++) begin
      #1;
      n_total++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'(j + 1) || bus.WD3 !== 32'(16 + j))
        $display("FAIL drain%0d got we=%0b a3=%0d wd=%0d exp we=1 a3=%0d wd=%0d", j, bus.WE3, bus.A3, bus.WD3, j + 1, 16 + j); else n_pass++;
      n_total++; if (bus.count !== 3'd3 - 3'(j - 2))
        $display("FAIL drain_count%0d got=%0d exp=%0d", j, bus.count, 5 - j); else n_pass++;
      @(posedge clk); #1;
    end
    #1;
    n_total++; if (bus.count !== 3'd0 || bus.WE3 !== 1'b0)
      $display("FAIL drained got count=%0d we=%0b exp count=0 we=0", bus.count, bus.WE3); else n_pass++;
  endtask

  task automatic test_same_reg();
    apply_reset();
    bus.wb_stall = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'd1;
    @(posedge clk); #1;
    bus.alu_data = 32'd2;
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
    #1;
    n_total++; if (bus.count !== 3'd2) $display("FAIL samereg_count got=%0d exp=2", bus.count); else n_pass++;
    n_total++; if (bus.pending_mask !== 32'h0000_0080) $display("FAIL samereg_mask0 got=%0h exp=80", bus.pending_mask); else n_pass++;
    bus.wb_stall = 1'b0;
    #1;
    n_total++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd7 || bus.WD3 !== 32'd1)
      $display("FAIL samereg_first got we=%0b a3=%0d wd=%0d exp we=1 a3=7 wd=1", bus.WE3, bus.A3, bus.WD3); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (bus.pending_mask !== 32'h0000_0080) $display("FAIL samereg_mask1 got=%0h exp=80", bus.pending_mask); else n_pass++;
    n_total++; if (bus.WE3 !== 1'b1 || bus.WD3 !== 32'd2)
      $display("FAIL samereg_second got we=%0b wd=%0d exp we=1 wd=2", bus.WE3, bus.WD3); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (bus.pending_mask !== 32'd0 || bus.WE3 !== 1'b0)
      $display("FAIL samereg_done got mask=%0h we=%0b exp mask=0 we=0", bus.pending_mask, bus.WE3); else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(20 + k); bus.mem_data = 32'(768 + k);
      @(posedge clk); #1;
    end
    bus.mem_valid = 1'b0;
    #1;
    n_total++; if (bus.count !== 3'd3) $display("FAIL mid_count got=%0d exp=3", bus.count); else n_pass++;
    n_total++; if (bus.pending_mask !== 32'h0070_0000) $display("FAIL mid_mask got=%0h exp=700000", bus.pending_mask); else n_pass++;
    bus.wb_stall = 1'b0;
    #1;
    n_total++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd20)
      $display("FAIL mid_head got we=%0b a3=%0d exp we=1 a3=20", bus.WE3, bus.A3); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (bus.WE3 !== 1'b0 || bus.count !== 3'd0 || bus.pending_mask !== 32'd0 || bus.A3 !== 5'd0)
      $display("FAIL mid_async got we=%0b count=%0d mask=%0h a3=%0d exp all 0", bus.WE3, bus.count, bus.pending_mask, bus.A3); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if (bus.WE3 !== 1'b0 || bus.count !== 3'd0)
        $display("FAIL mid_after%0d got we=%0b count=%0d exp we=0 count=0", k, bus.WE3, bus.count); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0();
    apply_reset();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
    #1;
    n_total++; if (bus.alu_ready !== 1'b1) $display("FAIL x0_ready got=%0b exp=1", bus.alu_ready); else n_pass++;
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
    #1;
`ifdef WB_DROP_X0_EN
    n_total++; if (bus.count !== 3'd0 || bus.WE3 !== 1'b0 || bus.pending_mask !== 32'd0)
      $display("FAIL x0_drop got count=%0d we=%0b mask=%0h exp 0/0/0", bus.count, bus.WE3, bus.pending_mask); else n_pass++;
`else
    n_total++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd0 || bus.WD3 !== 32'h55 || bus.count !== 3'd1)
      $display("FAIL x0_write got we=%0b a3=%0d wd=%0h count=%0d exp we=1 a3=0 wd=55 count=1",
               bus.WE3, bus.A3, bus.WD3, bus.count); else n_pass++;
    n_total++; if (bus.pending_mask !== 32'h0000_0001) $display("FAIL x0_mask got=%0h exp=1", bus.pending_mask); else n_pass++;
`endif
    @(posedge clk); #2;
    n_total++; if (bus.WE3 !== 1'b0 || bus.count !== 3'd0)
      $display("FAIL x0_after got we=%0b count=%0d exp we=0 count=0", bus.WE3, bus.count); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall_full();
    test_same_reg();
    test_reset_mid();
    test_x0();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
